// File: rtl/bcd_scan_display.sv
// ----------------------------------------------------------------------------
// bcd_scan_display
//   Time-multiplexed driver for an 8-digit common-anode 7-segment display.
//   It shows three unsigned counters as decimal fields:
//     press   -> AN7..AN5 (hundreds, tens, units)
//     hold    -> AN4..AN3 (tens, units), saturated at 99
//     release -> AN2..AN0 (hundreds, tens, units)
//   A serial double-dabble converter refreshes the fields once per scan
//   frame. The three inputs are snapshotted together, and the display
//   registers update together, so a frame never mixes old and new values.
//
// Parameters
//   SCAN_DIV  clock cycles each digit stays active (>= 2)
//   LZ_BLANK  1: blank leading zeros in each field, 0: show them as "0"
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   press_count    left field value
//   hold_count     middle field value
//   release_count  right field value
//   segments       {CA..CG}, active-low
//   anodos         {AN7..AN0}, active-low, exactly one bit low
//   conv_busy      high while the converter is outside IDLE
// ----------------------------------------------------------------------------
module bcd_scan_display #(
   parameter int SCAN_DIV = 100000,
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] press_count,
   input  logic [7:0] hold_count,
   input  logic [7:0] release_count,
   output logic [6:0] segments,
   output logic [7:0] anodos,
   output logic       conv_busy
);

   localparam int               CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} conv_state_e;

   // Scan timing
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             scan_tick;
   logic             boot_q;
   logic             start_req;

   // Converter
   conv_state_e state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  field_q, field_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [11:0] bcd_adj;
   logic [7:0]  snap_hold_q, snap_hold_d;
   logic [7:0]  snap_rel_q, snap_rel_d;

   // Shadow and display registers (BCD nibbles)
   logic [11:0] sh_press_q, sh_press_d;
   logic [7:0]  sh_hold_q, sh_hold_d;
   logic [11:0] disp_press_q, disp_press_d;
   logic [7:0]  disp_hold_q, disp_hold_d;
   logic [11:0] disp_rel_q, disp_rel_d;

   // Display mux
   logic [3:0] digit;
   logic       blank;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b0000001;
         4'd1:    seg_of = 7'b1001111;
         4'd2:    seg_of = 7'b0010010;
         4'd3:    seg_of = 7'b0000110;
         4'd4:    seg_of = 7'b1001100;
         4'd5:    seg_of = 7'b0100100;
         4'd6:    seg_of = 7'b0100000;
         4'd7:    seg_of = 7'b0001111;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0000100;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [11:0] dd_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int n = 0; n < 3; n++) begin
         if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // Prescaler and digit index
   // -------------------------------------------------------------------------
   always_comb begin : scan_next
      scan_tick = (cnt_q == CNT_MAX);
      cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
      idx_d     = scan_tick ? idx_q + 3'd1 : idx_q;
      // boot_q requests the first pass right after reset; later passes start
      // when the index wraps 7->0.
      start_req = boot_q | (scan_tick & (idx_q == 3'd7));
   end

   // -------------------------------------------------------------------------
   // Converter next-state / datapath
   // -------------------------------------------------------------------------
   always_comb begin : conv_next
      // NOTE: every signal driven here gets a default first so no path
      // through the case statement leaves one unassigned (which would infer
      // a latch).
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      field_d      = field_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      snap_hold_d  = snap_hold_q;
      snap_rel_d   = snap_rel_q;
      sh_press_d   = sh_press_q;
      sh_hold_d    = sh_hold_q;
      disp_press_d = disp_press_q;
      disp_hold_d  = disp_hold_q;
      disp_rel_d   = disp_rel_q;
      bcd_adj      = dd_adjust(bcd_q);

      case (state_q)
         IDLE: begin
            // Requests arriving while busy are simply not looked at.
            if (start_req) state_d = LOAD;
         end
         LOAD: begin
            // All three inputs are captured on this one cycle.
            bin_d       = press_count;
            bcd_d       = '0;
            snap_hold_d = (hold_count > 8'd99) ? 8'd99 : hold_count;
            snap_rel_d  = release_count;
            field_d     = 2'd0;
            bit_cnt_d   = 3'd0;
            state_d     = SHIFT;
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            bit_cnt_d      = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STORE;
         end
         STORE: begin
            bit_cnt_d = 3'd0;
            bcd_d     = '0;
            case (field_q)
               2'd0: begin
                  sh_press_d = bcd_q;
                  bin_d      = snap_hold_q;
                  field_d    = 2'd1;
                  state_d    = SHIFT;
               end
               2'd1: begin
                  sh_hold_d = bcd_q[7:0];
                  bin_d     = snap_rel_q;
                  field_d   = 2'd2;
                  state_d   = SHIFT;
               end
               default: begin
                  // Final store: publish all three fields on the same edge.
                  disp_press_d = sh_press_q;
                  disp_hold_d  = sh_hold_q;
                  disp_rel_d   = bcd_q;
                  state_d      = IDLE;
               end
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         boot_q       <= 1'b1;
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         field_q      <= 2'd0;
         bin_q        <= 8'd0;
         bcd_q        <= 12'd0;
         snap_hold_q  <= 8'd0;
         snap_rel_q   <= 8'd0;
         sh_press_q   <= 12'd0;
         sh_hold_q    <= 8'd0;
         disp_press_q <= 12'd0;
         disp_hold_q  <= 8'd0;
         disp_rel_q   <= 12'd0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         boot_q       <= 1'b0;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         field_q      <= field_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         snap_hold_q  <= snap_hold_d;
         snap_rel_q   <= snap_rel_d;
         sh_press_q   <= sh_press_d;
         sh_hold_q    <= sh_hold_d;
         disp_press_q <= disp_press_d;
         disp_hold_q  <= disp_hold_d;
         disp_rel_q   <= disp_rel_d;
      end
   end

   // -------------------------------------------------------------------------
   // Digit select, leading-zero blanking, segment decode
   // -------------------------------------------------------------------------
   always_comb begin : display_mux
      digit = 4'd0;
      blank = 1'b0;
      case (idx_q)
         3'd0: digit = disp_rel_q[3:0];
         3'd1: begin
            digit = disp_rel_q[7:4];
            blank = LZ_BLANK && (disp_rel_q[11:4] == 8'd0);
         end
         3'd2: begin
            digit = disp_rel_q[11:8];
            blank = LZ_BLANK && (disp_rel_q[11:8] == 4'd0);
         end
         3'd3: digit = disp_hold_q[3:0];
         3'd4: begin
            // Hold has no hundreds digit, so its tens blank on zero alone.
            digit = disp_hold_q[7:4];
            blank = LZ_BLANK && (disp_hold_q[7:4] == 4'd0);
         end
         3'd5: digit = disp_press_q[3:0];
         3'd6: begin
            digit = disp_press_q[7:4];
            blank = LZ_BLANK && (disp_press_q[11:4] == 8'd0);
         end
         3'd7: begin
            digit = disp_press_q[11:8];
            blank = LZ_BLANK && (disp_press_q[11:8] == 4'd0);
         end
         default: ;
      endcase
      segments  = blank ? 7'b1111111 : seg_of(digit);
      anodos    = ~(8'd1 << idx_q);
      conv_busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// ----------------------------------------------------------------------------
// tb_bcd_scan_display
//   Directed bench for bcd_scan_display with SCAN_DIV=4, LZ_BLANK=1.
//   With SCAN_DIV=4 a frame is 32 cycles and a wrap-started pass commits
//   exactly when AN7 becomes active, so a 32-cycle window starting there
//   (AN7, AN0..AN6) sees one stable set of display registers.
// ----------------------------------------------------------------------------
module tb_bcd_scan_display;

   logic       clock;
   logic       reset;
   logic [7:0] press_count;
   logic [7:0] hold_count;
   logic [7:0] release_count;
   logic [6:0] segments;
   logic [7:0] anodos;
   logic       conv_busy;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b0100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] BL = 7'b1111111;

   // Expected segments per digit index, written {idx7, idx6, ..., idx0}.
   localparam logic [7:0][6:0] ZERO_DISP = {BL, BL, S0, BL, S0, BL, BL, S0};

   bcd_scan_display #(
      .SCAN_DIV (4),
      .LZ_BLANK (1'b1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .press_count   (press_count),
      .hold_count    (hold_count),
      .release_count (release_count),
      .segments      (segments),
      .anodos        (anodos),
      .conv_busy     (conv_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [7:0] p, input logic [7:0] h, input logic [7:0] r);
      press_count   = p;
      hold_count    = h;
      release_count = r;
   endtask

   task automatic wait_busy(input logic val, input string tag);
      int g;
      g = 0;
      while (conv_busy !== val && g < 200) begin
         @(negedge clock);
         g++;
      end
      check(tag, {7'd0, conv_busy}, {7'd0, val});
   endtask

   // Wait for a pass that loaded the inputs currently applied to complete.
   task automatic wait_pass(input string tag);
      wait_busy(1'b0, {tag, " idle"});
      wait_busy(1'b1, {tag, " start"});
      wait_busy(1'b0, {tag, " done"});
   endtask

   // Called on the cycle a wrap-started pass has just committed (AN7 active).
   task automatic scan(input string tag, input logic [7:0][6:0] exp);
      for (int j = 0; j < 32; j++) begin
         int         slot;
         logic [7:0] an_exp;
         slot   = (7 + j / 4) % 8;
         an_exp = ~(8'd1 << slot);
         check($sformatf("%s an j%0d", tag, j), anodos, an_exp);
         check($sformatf("%s seg idx%0d", tag, slot), {1'b0, segments}, {1'b0, exp[slot]});
         @(negedge clock);
      end
   endtask

   // Hold reset for n cycles, check reset outputs, then follow the boot pass:
   // display stays all zeros/blanks, busy lasts 28 cycles, and the fresh
   // frame is visible on AN7 as soon as it commits.
   task automatic reset_and_check(input int n, input logic [6:0] an7_exp);
      int busy_cnt;
      int g;
      reset = 1'b1;
      repeat (n) @(negedge clock);
      check("rst busy", {7'd0, conv_busy}, 8'h00);
      check("rst anodos", anodos, 8'hFE);
      check("rst seg", {1'b0, segments}, {1'b0, S0});
      reset    = 1'b0;
      busy_cnt = 0;
      for (int j = 0; j < 28; j++) begin
         logic [7:0] an_exp;
         an_exp = ~(8'd1 << (j / 4));
         check($sformatf("boot an j%0d", j), anodos, an_exp);
         check($sformatf("boot seg j%0d", j), {1'b0, segments}, {1'b0, ZERO_DISP[j / 4]});
         if (j == 1) check("busy 2nd cycle", {7'd0, conv_busy}, 8'h01);
         if (conv_busy === 1'b1) busy_cnt++;
         @(negedge clock);
      end
      g = 0;
      while (conv_busy === 1'b1 && g < 50) begin
         busy_cnt++;
         g++;
         @(negedge clock);
      end
      check("busy length", 8'(busy_cnt), 8'd28);
      check("boot commit an", anodos, 8'h7F);
      check("boot commit seg", {1'b0, segments}, {1'b0, an7_exp});
   endtask

   initial begin
      reset = 1'b1;
      apply(8'd0, 8'd0, 8'd0);

      // Power-on reset with zero inputs.
      reset_and_check(3, BL);

      // Mixed widths: three-digit, two-digit, single-digit fields.
      apply(8'd255, 8'd42, 8'd7);
      wait_pass("v1");
      scan("v1", {S2, S5, S5, S4, S2, BL, BL, S7});

      // Hold saturation, zero press, maximum release.
      apply(8'd0, 8'd150, 8'd255);
      wait_pass("v2");
      scan("v2", {BL, BL, S0, S9, S9, S2, S5, S5});

      // Single-digit hold, inner zero kept when hundreds is shown.
      apply(8'd10, 8'd5, 8'd100);
      wait_pass("v3");
      scan("v3", {BL, S1, S0, BL, S5, S1, S0, S0});

      // Change press mid-SHIFT: this pass must still publish 10.
      wait_busy(1'b1, "mid start");
      repeat (2) @(negedge clock);
      press_count = 8'd200;
      wait_busy(1'b0, "mid done");
      scan("v3 kept", {BL, S1, S0, BL, S5, S1, S0, S0});
      // The window above ends exactly as the next pass commits.
      scan("v4", {S2, S0, S0, BL, S5, S1, S0, S0});

      // Reset during the 4th SHIFT of the hold value.
      apply(8'd123, 8'd67, 8'd89);
      wait_busy(1'b1, "abort start");
      repeat (13) @(negedge clock);
      reset_and_check(1, S1);
      wait_pass("v5");
      scan("v5", {S1, S2, S3, S6, S7, BL, S8, S9});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter SCAN_DIV, 100000, clock cycles each digit stays active (minimum 2).
REQ-002 Parameter LZ_BLANK, 1, when 1 leading zeros of each field are blanked; when 0 they show as "0".
REQ-003 clock  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 press_count  in  8  unsigned value for the left field.
REQ-006 hold_count  in  8  unsigned value for the middle field.
REQ-007 release_count  in  8  unsigned value for the right field.
REQ-008 segments  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low.
REQ-009 anodos  out  8  {AN7..AN0}, active-low, exactly one bit low at all times.
REQ-010 conv_busy  out  1  high while the converter FSM is outside IDLE.

Function
REQ-011 Field map SHALL be: press on AN7..AN5 (hundreds..units), hold on AN4..AN3 (tens, units), release on AN2..AN0 (hundreds..units).
REQ-012 Hold field SHALL saturate: hold_count > 99 displays "99".
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan tick SHALL assert on the cycle the count equals SCAN_DIV-1.
REQ-014 Digit index SHALL increment by one on each scan tick, in order 0..7, wrapping 7->0; anodos SHALL equal ~(1<<index).
REQ-015 Segment code SHALL be combinational from the displayed digit: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111.
REQ-016 With LZ_BLANK=1, a hundreds digit of 0 SHALL blank; a tens digit of 0 SHALL blank when its field's hundreds digit is blank or absent; units SHALL never blank.
REQ-017 Converter FSM states SHALL be IDLE, LOAD, SHIFT, STORE.
REQ-018 IDLE->LOAD on the cycle after reset deasserts, and on every scan tick where index goes 7->0.
REQ-019 LOAD (1 cycle) SHALL snapshot all three inputs at once; input changes after LOAD SHALL NOT affect the current pass.
REQ-020 SHIFT SHALL run double-dabble, one bit per cycle, MSB first: add 3 to any BCD nibble >=5, then shift left; 8 cycles per value.
REQ-021 The sequence SHALL be press, hold, release: LOAD, then 3x(8 SHIFT + 1 STORE), then IDLE; conv_busy high for 28 cycles.
REQ-022 STORE SHALL write into shadow registers; the three display registers SHALL update together on the final STORE, so no partial frame is ever shown.
REQ-023 A start request during conv_busy SHALL be ignored; the next request comes at the following 7->0 wrap.
REQ-024 Value 0 SHALL display "0" in the units digit only (LZ_BLANK=1); value 255 SHALL display "255".

Reset
REQ-025 While reset is high: prescaler=0, index=0, FSM=IDLE, conv_busy=0, shadow and display registers=0.
REQ-026 Outputs after reset: anodos=8'b11111110, segments=7'b0000001 (units "0").
REQ-027 Reset asserted mid-conversion SHALL abort the pass with no partial display update; the FSM SHALL restart per REQ-018.

Verification (SCAN_DIV=4, LZ_BLANK=1)
REQ-028 Reset 3 cycles, inputs 0 -> anodos=FE, segments=0000001; conv_busy high for 28 cycles from the second cycle after release.
REQ-029 press=255, hold=42, release=7, one conversion -> AN7..AN0 show 2,5,5,4,2,blank,blank,7; each anode low exactly 4 cycles; order AN0..AN7 then wrap.
REQ-030 hold=150 -> AN4..AN3 show 9,9; hold=5 -> AN4 blank, AN3 shows 5.
REQ-031 press changes 10->200 during SHIFT -> display keeps 10 (AN6=1, AN5=0, AN7 blank) until the pass after the next 7->0 wrap, then shows 200.
REQ-032 Reset pulsed at SHIFT cycle 4 of the hold value -> display returns to all zeros/blanks; new pass starts and completes 28 cycles later with current inputs.
